// File: rtl/pe_pkg.sv
// pe_pkg: saturation limits and saturating add shared by the PE accumulator.
package pe_pkg;
  localparam int MAX_W = 64;
  typedef logic signed [MAX_W+1:0] wide_t;
  function automatic wide_t max_val(int w, bit s);
    return s ? (wide_t'(1) <<< (w - 1)) - wide_t'(1) : (wide_t'(1) <<< w) - wide_t'(1);
  endfunction
  function automatic wide_t min_val(int w, bit s);
    return s ? -(wide_t'(1) <<< (w - 1)) : '0;
  endfunction
  function automatic wide_t widen(logic [MAX_W-1:0] x, bit s);
    return s ? {{2{x[MAX_W-1]}}, x} : {2'b0, x};
  endfunction
  function automatic logic [MAX_W-1:0] sat_add(logic [MAX_W-1:0] x, logic [MAX_W-1:0] y, int w, bit s);
    wide_t t;
    t = widen(x, s) + widen(y, s);
    return MAX_W'(t > max_val(w, s) ? max_val(w, s) : t < min_val(w, s) ? min_val(w, s) : t);
  endfunction
  function automatic bit sat_hit(logic [MAX_W-1:0] x, logic [MAX_W-1:0] y, int w, bit s);
    wide_t t;
    t = widen(x, s) + widen(y, s);
    return t > max_val(w, s) || t < min_val(w, s);
  endfunction
endpackage

// File: rtl/pe_sat_acc.sv
// pe_sat_acc: saturating frame accumulator with per-frame clamp sticky and result register.
module pe_sat_acc import pe_pkg::*; #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fire,
  input  logic              clr,
  input  logic              last,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  c_out,
  output logic              c_vld,
  output logic              c_sat
);
  localparam bit SG = SIGNED != 0;
  logic [ACC_W-1:0] acc, acc_nx;
  logic             sat, sat_nx;
  logic [MAX_W-1:0] prod_x, acc_x;
  // clr starts from zero, so a frame's first pair reports only its own clamp
  always_comb begin
    prod_x = {{(MAX_W-PROD_W){SG && prod[PROD_W-1]}}, prod};
    acc_x  = clr ? '0 : {{(MAX_W-ACC_W){SG && acc[ACC_W-1]}}, acc};
    acc_nx = ACC_W'(sat_add(acc_x, prod_x, ACC_W, SG));
    sat_nx = sat_hit(acc_x, prod_x, ACC_W, SG) | (~clr & sat);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      sat   <= 1'b0;
      c_out <= '0;
      c_vld <= 1'b0;
      c_sat <= 1'b0;
    end else if (en) begin
      if (fire) begin
        acc <= acc_nx;
        sat <= sat_nx;
      end
      c_vld <= fire & last;
      if (fire & last) begin
        c_out <= acc_nx;
        c_sat <= sat_nx;
      end
    end
  end
endmodule

// File: rtl/pe_mac_v2.sv
// pe_mac_v2: systolic MAC PE; forwards A east / B south and accumulates framed A*B with saturation.
module pe_mac_v2 import pe_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vld_in,
  input  logic              clr_in,
  input  logic              last_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_vld_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vld_out,
  output logic              clr_out,
  output logic              last_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_vld_out,
  output logic [ACC_W-1:0]  c_out,
  output logic              c_vld,
  output logic              c_sat,
  output logic              err_mis
);
  localparam int PW = 2 * DATA_W;
  if (ACC_W < PW || ACC_W >= MAX_W) begin : g_bad_acc_w
    $error("pe_mac_v2: ACC_W must be >= 2*DATA_W and < %0d", MAX_W);
  end
  logic [DATA_W-1:0] a_s0, b_s0;
  logic              a_vld_s0, b_vld_s0, clr_s0, last_s0, err_r;
  logic              fire_s1, clr_s1, last_s1;
  logic [PW-1:0]     prod_s1, a_x, b_x;
  // operands are widened to the product width so the low PW bits are exact in either mode
  always_comb begin
    a_x = {{DATA_W{SIGNED != 0 && a_s0[DATA_W-1]}}, a_s0};
    b_x = {{DATA_W{SIGNED != 0 && b_s0[DATA_W-1]}}, b_s0};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_s0     <= '0;
      b_s0     <= '0;
      a_vld_s0 <= 1'b0;
      b_vld_s0 <= 1'b0;
      clr_s0   <= 1'b0;
      last_s0  <= 1'b0;
      err_r    <= 1'b0;
      fire_s1  <= 1'b0;
      clr_s1   <= 1'b0;
      last_s1  <= 1'b0;
      prod_s1  <= '0;
    end else if (en) begin
      a_s0     <= a_in;
      b_s0     <= b_in;
      a_vld_s0 <= a_vld_in;
      b_vld_s0 <= b_vld_in;
      clr_s0   <= clr_in;
      last_s0  <= last_in;
      err_r    <= err_r | (a_vld_in != b_vld_in);
      fire_s1  <= a_vld_s0 & b_vld_s0;
      clr_s1   <= clr_s0;
      last_s1  <= last_s0;
      prod_s1  <= a_x * b_x;
    end
  end
  assign a_out     = a_s0;
  assign b_out     = b_s0;
  assign a_vld_out = a_vld_s0;
  assign b_vld_out = b_vld_s0;
  assign clr_out   = clr_s0;
  assign last_out  = last_s0;
  assign err_mis   = err_r;
  pe_sat_acc #(.PROD_W(PW), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .fire  (fire_s1),
    .clr   (clr_s1),
    .last  (last_s1),
    .prod  (prod_s1),
    .c_out (c_out),
    .c_vld (c_vld),
    .c_sat (c_sat)
  );
endmodule

// File: tb/tb_pe_mac_v2.sv
// tb_pe_mac_v2: unsigned and signed PEs (DATA_W=8, ACC_W=16) driven in parallel against a frame-level model.
module tb_pe_mac_v2;
  logic clk = 0, rst = 1, en = 0;
  logic a_vld_in = 0, b_vld_in = 0, clr_in = 0, last_in = 0;
  logic [7:0] a_in = 0, b_in = 0;
  logic [7:0] u_a_out, u_b_out, s_a_out, s_b_out;
  logic u_a_vld_out, u_clr_out, u_last_out, u_b_vld_out, u_c_vld, u_c_sat, u_err_mis;
  logic s_a_vld_out, s_clr_out, s_last_out, s_b_vld_out, s_c_vld, s_c_sat, s_err_mis;
  logic [15:0] u_c_out, s_c_out;

  pe_mac_v2 #(.DATA_W(8), .ACC_W(16), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .a_in(a_in), .a_vld_in(a_vld_in), .clr_in(clr_in),
    .last_in(last_in), .b_in(b_in), .b_vld_in(b_vld_in), .a_out(u_a_out), .a_vld_out(u_a_vld_out),
    .clr_out(u_clr_out), .last_out(u_last_out), .b_out(u_b_out), .b_vld_out(u_b_vld_out),
    .c_out(u_c_out), .c_vld(u_c_vld), .c_sat(u_c_sat), .err_mis(u_err_mis));
  pe_mac_v2 #(.DATA_W(8), .ACC_W(16), .SIGNED(1)) s_dut (
    .clk(clk), .rst(rst), .en(en), .a_in(a_in), .a_vld_in(a_vld_in), .clr_in(clr_in),
    .last_in(last_in), .b_in(b_in), .b_vld_in(b_vld_in), .a_out(s_a_out), .a_vld_out(s_a_vld_out),
    .clr_out(s_clr_out), .last_out(s_last_out), .b_out(s_b_out), .b_vld_out(s_b_vld_out),
    .c_out(s_c_out), .c_vld(s_c_vld), .c_sat(s_c_sat), .err_mis(s_err_mis));

  always #5 clk = ~clk;

  typedef struct { int cnt; longint v[2]; bit s[2]; } res_t;
  res_t q[$];
  longint sum[2], e_out[2];
  bit st[2], e_sat[2];
  bit e_vld, e_err, e_av, e_bv, e_clr, e_last, prev_en;
  logic [7:0] e_a, e_b;
  int checks = 0, errors = 0, cyc = 0;
  longint got_u[$], got_s[$];
  bit gsat_u[$], gsat_s[$];
  int got_cyc[$];

  task automatic chk(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("u_a_out", u_a_out, e_a);         chk("s_a_out", s_a_out, e_a);
    chk("u_b_out", u_b_out, e_b);         chk("s_b_out", s_b_out, e_b);
    chk("u_a_vld_out", u_a_vld_out, e_av); chk("s_a_vld_out", s_a_vld_out, e_av);
    chk("u_b_vld_out", u_b_vld_out, e_bv); chk("s_b_vld_out", s_b_vld_out, e_bv);
    chk("u_clr_out", u_clr_out, e_clr);   chk("s_clr_out", s_clr_out, e_clr);
    chk("u_last_out", u_last_out, e_last); chk("s_last_out", s_last_out, e_last);
    chk("u_c_vld", u_c_vld, e_vld);       chk("s_c_vld", s_c_vld, e_vld);
    chk("u_c_out", u_c_out, e_out[0]);    chk("s_c_out", longint'($signed(s_c_out)), e_out[1]);
    chk("u_c_sat", u_c_sat, e_sat[0]);    chk("s_c_sat", s_c_sat, e_sat[1]);
    chk("u_err_mis", u_err_mis, e_err);   chk("s_err_mis", s_err_mis, e_err);
    if (u_c_vld && prev_en) begin
      got_u.push_back(u_c_out); got_s.push_back(longint'($signed(s_c_out)));
      gsat_u.push_back(u_c_sat); gsat_s.push_back(s_c_sat); got_cyc.push_back(cyc);
    end
  endtask

  task automatic model_clear();
    q.delete();
    sum = '{0, 0}; st = '{0, 0}; e_out = '{0, 0}; e_sat = '{0, 0};
    e_vld = 0; e_err = 0; e_av = 0; e_bv = 0; e_clr = 0; e_last = 0; e_a = 0; e_b = 0;
  endtask

  // frame arithmetic is done at pair-presentation time; the result appears 3 enabled edges later
  task automatic model(bit av, bit bv, logic [7:0] a, logic [7:0] b, bit c, bit l);
    longint p, t, hi, lo;
    res_t r;
    e_a = a; e_b = b; e_av = av; e_bv = bv; e_clr = c; e_last = l;
    if (av != bv) e_err = 1;
    foreach (q[i]) q[i].cnt--;
    e_vld = 0;
    if (q.size() > 0 && q[0].cnt == 0) begin
      e_vld = 1; e_out = q[0].v; e_sat = q[0].s;
      void'(q.pop_front());
    end
    if (av && bv) begin
      for (int m = 0; m < 2; m++) begin
        p  = m ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
        t  = c ? p : sum[m] + p;
        hi = m ? 32767 : 65535;
        lo = m ? -32768 : 0;
        sum[m] = t > hi ? hi : t < lo ? lo : t;
        st[m]  = (t > hi || t < lo) || (!c && st[m]);
      end
      if (l) begin
        r.cnt = 2; r.v = sum; r.s = st;
        q.push_back(r);
      end
    end
  endtask

  task automatic step(bit en_, bit av, bit bv, logic [7:0] a, logic [7:0] b, bit c, bit l);
    @(negedge clk);
    check_all();
    cyc++;
    en = en_; a_vld_in = av; b_vld_in = bv; a_in = a; b_in = b; clr_in = c; last_in = l;
    prev_en = en_;
    if (en_) model(av, bv, a, b, c, l);
  endtask

  task automatic pair(logic [7:0] a, logic [7:0] b, bit c, bit l);
    step(1, 1, 1, a, b, c, l);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step(1, 0, 0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_all();
    rst = 1; en = 0; a_vld_in = 0; b_vld_in = 0; prev_en = 0;
    model_clear();
    #1 check_all();
    @(negedge clk);
    check_all();
    rst = 0;
  endtask

  task automatic clear_got();
    got_u.delete(); got_s.delete(); gsat_u.delete(); gsat_s.delete(); got_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_clear();
    do_reset();
    // directed: unsigned sum of products
    clear_got();
    pair(3, 4, 1, 0); pair(5, 6, 0, 0); pair(7, 8, 0, 1); idle(5);
    chk("t1_count", got_u.size(), 1);
    if (got_u.size() == 1) begin chk("t1_c_out", got_u[0], 98); chk("t1_c_sat", gsat_u[0], 0); end
    // directed: signed frame then one-pair frame
    clear_got();
    pair(8'hFD, 4, 1, 0); pair(127, 8'h80, 0, 1); idle(1); pair(8'h80, 8'h80, 1, 1); idle(5);
    chk("t2_count", got_s.size(), 2);
    if (got_s.size() == 2) begin
      chk("t2_c_out0", got_s[0], -16268); chk("t2_c_out1", got_s[1], 16384);
      chk("t2_c_sat1", gsat_s[1], 0);
    end
    // directed: unsigned clamp, then a clean frame clears the sticky
    clear_got();
    pair(255, 255, 1, 0); pair(255, 255, 0, 0); pair(255, 255, 0, 1); pair(1, 1, 1, 1); idle(5);
    chk("t3_count", got_u.size(), 2);
    if (got_u.size() == 2) begin
      chk("t3_c_out0", got_u[0], 65535); chk("t3_c_sat0", gsat_u[0], 1);
      chk("t3_c_out1", got_u[1], 1);     chk("t3_c_sat1", gsat_u[1], 0);
    end
    // directed: back-to-back one-pair frames
    clear_got();
    pair(2, 2, 1, 1); pair(3, 3, 1, 1); idle(5);
    chk("t4_count", got_u.size(), 2);
    if (got_u.size() == 2) begin
      chk("t4_c_out0", got_u[0], 4); chk("t4_c_out1", got_u[1], 9);
      chk("t4_consecutive", got_cyc[1] - got_cyc[0], 1);
    end
    // directed: stall mid-frame and while c_vld is high
    clear_got();
    pair(10, 20, 1, 0); pair(30, 40, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    pair(50, 60, 0, 1); idle(2);
    for (int i = 0; i < 3; i++) step(0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    idle(3);
    chk("t5_count", got_u.size(), 1);
    if (got_u.size() == 1) chk("t5_c_out", got_u[0], 4400);
    // directed: valid mismatch leaves acc alone, then reset mid-frame drops the result
    do_reset();
    clear_got();
    pair(2, 3, 1, 0); step(1, 1, 0, 9, 9, 0, 1); pair(4, 5, 0, 1); idle(4);
    chk("t6_err_mis", u_err_mis, 1);
    chk("t6_count", got_u.size(), 1);
    if (got_u.size() == 1) chk("t6_c_out", got_u[0], 26);
    clear_got();
    pair(7, 7, 1, 0); pair(7, 7, 0, 1);
    do_reset();
    chk("t6_rst_c_out", u_c_out, 0);
    chk("t6_rst_err", u_err_mis, 0);
    idle(5);
    chk("t6_no_vld", got_u.size(), 0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit av, bv;
      logic [7:0] a, b;
      av = ($urandom_range(0, 9) < 7);
      bv = ($urandom_range(0, 29) == 0) ? !av : av;
      a = ($urandom_range(0, 3) == 0) ? 8'hFF : ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 8'hFF : ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      step($urandom_range(0, 9) != 0, av, bv, a, b, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
      if ($urandom_range(0, 199) == 0) do_reset();
    end
    idle(4);
    @(negedge clk);
    check_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
